// File: rtl/seq_detect_prog.sv
// ---------------------------------------------------------------------------
// seq_detect_prog
//
// Purpose:
//   Programmable serial-pattern detector. It watches a stream of SYM_W-bit
//   symbols and flags every occurrence of a runtime-programmable pattern of
//   1..MAX_LEN symbols. Matches may overlap, or the history can be cleared
//   after each match. A saturating counter tracks the number of matches.
//   Reset defaults reproduce the classic 4-step 2-bit detector (00,11,00,01).
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous, active-high reset
//   sym_valid  in   a stream symbol is presented this cycle
//   sym        in   stream symbol
//   overlap    in   1: keep history after a hit, 0: restart after a hit
//   cfg_we     in   write pat[cfg_idx]=cfg_sym and len=cfg_len
//   cfg_idx    in   pattern symbol index
//   cfg_sym    in   pattern symbol value
//   cfg_len    in   pattern length
//   cnt_clr    in   clear the match counter
//   match      out  1-cycle pulse: the last accepted symbol completed the pattern
//   match_cnt  out  saturating match count
//   fill       out  number of valid symbols in history (saturates at MAX_LEN)
//   cfg_err    out  1-cycle pulse: the configuration write was rejected
// ---------------------------------------------------------------------------
module seq_detect_prog #(
    parameter int SYM_W   = 2,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int RST_LEN = 4,
    parameter logic [MAX_LEN*SYM_W-1:0] RST_PAT = (MAX_LEN*SYM_W)'(8'h4C),
    localparam int IDX_W  = $clog2(MAX_LEN),
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym,
    input  logic             overlap,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [SYM_W-1:0] cfg_sym,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN_W-1:0] fill,
    output logic             cfg_err
);

    // Element 0 is the newest history symbol / the first pattern symbol.
    typedef logic [MAX_LEN-1:0][SYM_W-1:0] sym_vec_t;

    sym_vec_t         hist_q, hist_d;
    sym_vec_t         pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;
    logic             cfg_err_q, cfg_err_d;

    sym_vec_t         hist_shift;
    logic [LEN_W-1:0] fill_shift;
    logic             hit;
    logic             cfg_ok;

    // The oldest relevant symbol sits at hist[len-1] and must equal pat[0];
    // the newest, hist[0], must equal pat[len-1]. Entries past len are ignored.
    function automatic logic pattern_hit(input sym_vec_t h,
                                         input logic [LEN_W-1:0] f,
                                         input logic [LEN_W-1:0] l,
                                         input sym_vec_t p);
        logic ok;
        ok = (f >= l);
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k < int'(l)) begin
                if (h[IDX_W'(int'(l) - 1 - k)] != p[IDX_W'(k)]) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    // Next-state logic. A configuration write takes priority over a stream
    // symbol presented in the same cycle; that symbol is simply dropped.
    always_comb begin
        hist_d     = hist_q;
        pat_d      = pat_q;
        len_d      = len_q;
        fill_d     = fill_q;
        match_d    = 1'b0;
        cfg_err_d  = 1'b0;
        cnt_d      = cnt_clr ? '0 : cnt_q;
        hist_shift = {hist_q[MAX_LEN-2:0], sym};
        fill_shift = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        hit        = 1'b0;
        cfg_ok     = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN) &&
                     (int'(cfg_idx) < MAX_LEN);

        if (cfg_we) begin
            if (cfg_ok) begin
                pat_d[cfg_idx] = cfg_sym;
                len_d          = cfg_len;
                fill_d         = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (sym_valid) begin
            hit     = pattern_hit(hist_shift, fill_shift, len_q, pat_q);
            hist_d  = hist_shift;
            fill_d  = (hit && !overlap) ? '0 : fill_shift;
            match_d = hit;
            // Counting after the optional clear gives "clear then count".
            if (hit && (cnt_d != '1)) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    // State register with synchronous reset back to the default detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            pat_q     <= RST_PAT;
            len_q     <= LEN_W'(RST_LEN);
            fill_q    <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign fill      = fill_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_prog
//
// Self-checking bench for seq_detect_prog (SYM_W=2, MAX_LEN=8, CNT_W=2).
// A queue-based reference model keeps the accepted symbols since the last
// history clear; a hit is simply "the last len symbols equal the pattern".
// Directed scenarios are followed by a randomized stream.
// ---------------------------------------------------------------------------
module tb_seq_detect_prog;

    localparam int SYM_W   = 2;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;

    logic       clk;
    logic       rst;
    logic       sym_valid;
    logic [1:0] sym;
    logic       overlap;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [1:0] cfg_sym;
    logic [3:0] cfg_len;
    logic       cnt_clr;
    logic       match;
    logic [1:0] match_cnt;
    logic [3:0] fill;
    logic       cfg_err;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state
    logic [1:0] m_hist[$];
    logic [1:0] m_pat[MAX_LEN];
    int         m_len;
    int         m_cnt;
    logic       m_match;
    logic       m_err;

    seq_detect_prog #(
        .SYM_W  (SYM_W),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sym_valid(sym_valid),
        .sym      (sym),
        .overlap  (overlap),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_sym  (cfg_sym),
        .cfg_len  (cfg_len),
        .cnt_clr  (cnt_clr),
        .match    (match),
        .match_cnt(match_cnt),
        .fill     (fill),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation and tally the result
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model reset values: default pattern 00,11,00,01 with length 4
    task automatic modelReset();
        m_hist.delete();
        for (int i = 0; i < MAX_LEN; i++) m_pat[i] = 2'b00;
        m_pat[1] = 2'b11;
        m_pat[3] = 2'b01;
        m_len   = 4;
        m_cnt   = 0;
        m_match = 1'b0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs applied to the DUT
    task automatic modelStep(input logic r, input logic v, input logic [1:0] s,
                             input logic ov, input logic we, input logic [2:0] idx,
                             input logic [1:0] cs, input logic [3:0] cl,
                             input logic clr);
        int n;
        logic ok;
        if (r) begin
            modelReset();
            return;
        end
        m_match = 1'b0;
        m_err   = 1'b0;
        if (clr) m_cnt = 0;
        if (we) begin
            if (cl >= 1 && cl <= MAX_LEN) begin
                m_pat[idx] = cs;
                m_len      = cl;
                m_hist.delete();
            end else begin
                m_err = 1'b1;
            end
        end else if (v) begin
            m_hist.push_back(s);
            if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
            n  = m_hist.size();
            ok = (n >= m_len);
            if (ok) begin
                for (int k = 0; k < m_len; k++) begin
                    if (m_hist[n - m_len + k] != m_pat[k]) ok = 1'b0;
                end
            end
            if (ok) begin
                m_match = 1'b1;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (!ov) m_hist.delete();
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then check all outputs vs the model
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                                 input logic ov, input logic we, input logic [2:0] idx,
                                 input logic [1:0] cs, input logic [3:0] cl,
                                 input logic clr);
        rst       = r;
        sym_valid = v;
        sym       = s;
        overlap   = ov;
        cfg_we    = we;
        cfg_idx   = idx;
        cfg_sym   = cs;
        cfg_len   = cl;
        cnt_clr   = clr;
        @(posedge clk);
        modelStep(r, v, s, ov, we, idx, cs, cl, clr);
        #1;
        checkOutput("match",     32'(match),     32'(m_match));
        checkOutput("match_cnt", 32'(match_cnt), 32'(m_cnt));
        checkOutput("fill",      32'(fill),      32'(m_hist.size()));
        checkOutput("cfg_err",   32'(cfg_err),   32'(m_err));
    endtask

    task automatic sendSym(input logic [1:0] s, input logic ov);
        applyStimulus(1'b0, 1'b1, s, ov, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic idleCycle(input logic clr);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 2'd0, 4'd0, clr);
    endtask

    task automatic writeCfg(input logic [2:0] idx, input logic [1:0] cs,
                            input logic [3:0] cl);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, idx, cs, cl, 1'b0);
    endtask

    initial begin
        logic       r, v, ov, we, clr;
        logic [1:0] s, cs;
        logic [2:0] idx;
        logic [3:0] cl;
        int         u;

        modelReset();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0);
        checkOutput("rst_fill", 32'(fill), 32'd0);
        checkOutput("rst_cnt",  32'(match_cnt), 32'd0);

        // Default pattern 00,11,00,01
        sendSym(2'b00, 1'b1); sendSym(2'b11, 1'b1);
        sendSym(2'b00, 1'b1); sendSym(2'b01, 1'b1);
        checkOutput("dflt_match", 32'(match), 32'd1);
        checkOutput("dflt_cnt",   32'(match_cnt), 32'd1);

        // Near-miss prefix must not hit early
        sendSym(2'b00, 1'b1); sendSym(2'b11, 1'b1);
        sendSym(2'b00, 1'b1); sendSym(2'b11, 1'b1);
        checkOutput("nomiss_match", 32'(match), 32'd0);
        sendSym(2'b00, 1'b1); sendSym(2'b01, 1'b1);
        checkOutput("late_cnt", 32'(match_cnt), 32'd2);
        idleCycle(1'b1);
        checkOutput("clr_cnt", 32'(match_cnt), 32'd0);

        // Pattern 10,10 with and without overlap
        writeCfg(3'd0, 2'b10, 4'd2);
        writeCfg(3'd1, 2'b10, 4'd2);
        sendSym(2'b10, 1'b1); sendSym(2'b10, 1'b1); sendSym(2'b10, 1'b1);
        checkOutput("ovl_cnt", 32'(match_cnt), 32'd2);
        idleCycle(1'b1);
        writeCfg(3'd1, 2'b10, 4'd2);
        sendSym(2'b10, 1'b0); sendSym(2'b10, 1'b0); sendSym(2'b10, 1'b0);
        checkOutput("novl_cnt",  32'(match_cnt), 32'd1);
        checkOutput("novl_fill", 32'(fill), 32'd1);

        // Restore default pattern, stream with gaps
        writeCfg(3'd0, 2'b00, 4'd4);
        writeCfg(3'd1, 2'b11, 4'd4);
        writeCfg(3'd2, 2'b00, 4'd4);
        writeCfg(3'd3, 2'b01, 4'd4);
        sendSym(2'b00, 1'b1);
        idleCycle(1'b0); idleCycle(1'b0); idleCycle(1'b0);
        sendSym(2'b11, 1'b1); sendSym(2'b00, 1'b1); sendSym(2'b01, 1'b1);
        checkOutput("gap_match", 32'(match), 32'd1);

        // Config write mid-pattern restarts the history
        sendSym(2'b00, 1'b1); sendSym(2'b11, 1'b1);
        writeCfg(3'd7, 2'b00, 4'd4);
        sendSym(2'b00, 1'b1); sendSym(2'b01, 1'b1);
        checkOutput("midcfg_match", 32'(match), 32'd0);
        checkOutput("midcfg_fill",  32'(fill), 32'd2);

        // Counter saturation with a length-1 pattern
        idleCycle(1'b1);
        writeCfg(3'd0, 2'b00, 4'd1);
        for (int i = 0; i < 5; i++) sendSym(2'b00, 1'b1);
        checkOutput("sat_cnt", 32'(match_cnt), 32'd3);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1);
        checkOutput("clrhit_cnt", 32'(match_cnt), 32'd1);

        // Rejected config writes, with a colliding symbol that must be dropped
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 3'd0, 2'b11, 4'd0, 1'b0);
        checkOutput("len0_err",   32'(cfg_err), 32'd1);
        checkOutput("len0_match", 32'(match), 32'd0);
        checkOutput("len0_fill",  32'(fill), 32'd6);
        sendSym(2'b00, 1'b1);
        checkOutput("len0_keep", 32'(match), 32'd1);
        writeCfg(3'd0, 2'b11, 4'd9);
        checkOutput("len9_err", 32'(cfg_err), 32'd1);
        sendSym(2'b00, 1'b1);
        checkOutput("len9_keep", 32'(match), 32'd1);

        // Reset in the middle of a pattern loses it
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0);
        sendSym(2'b00, 1'b1); sendSym(2'b11, 1'b1); sendSym(2'b00, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0);
        sendSym(2'b01, 1'b1);
        checkOutput("rstmid_match", 32'(match), 32'd0);

        // Randomized traffic with short patterns so hits are frequent
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            v   = ($urandom_range(0, 3) != 0);
            s   = 2'($urandom_range(0, 3));
            ov  = 1'($urandom_range(0, 1));
            we  = ($urandom_range(0, 19) == 0);
            idx = 3'($urandom_range(0, 7));
            cs  = 2'($urandom_range(0, 3));
            u   = $urandom_range(0, 9);
            cl  = (u == 0) ? 4'd0 :
                  (u == 1) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 3));
            clr = ($urandom_range(0, 29) == 0);
            applyStimulus(r, v, s, ov, we, idx, cs, cl, clr);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
